note_osc_ctrl: RTL and testbench

Consumer side of the note-frequency ROM. It accepts a note number over a valid/ready handshake and reads the matching 16-bit period word from the ROM. It then runs a down-counter that emits one sample-step pulse every `period` clocks, plus a square-wave reference. It sits between the note/key front end and the tri/squ/sin waveform generators, which advance their phase on `step`.

---
 rtl/note_osc_ctrl.sv | 141 ++++++++++++++
 tb/tb_note_osc_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/note_osc_ctrl.sv
// note_osc_ctrl: fetches a note's period word from the note-frequency ROM and
//   runs a down-counter that pulses `step` every `period` clocks, with a
//   square-wave reference `squ` toggling on every step.
// Latency: accept at T, rom_en at T+1, LOAD at T+2, active from T+3,
//   first step at T+2+P (P = ROM word), then every P clocks.
// Backpressure: note_ready is high only in IDLE (also in RUN when
//   NOTE_OSC_RETRIG_EN is defined); a request without note_ready is ignored.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   note_valid/ready  note request handshake, note_num = ROM address
//   note_off          stop the running note / abort an in-flight fetch
//   rom_en, rom_addr  ROM read strobe (FETCH only) and registered address
//   rom_data          ROM registered output, valid the cycle after rom_en
//   step, squ         sample-step pulse and square-wave reference
//   active, err       running flag, sticky "note mapped to period 0"
//
// Build option: define NOTE_OSC_RETRIG_EN to accept new notes while running.

module note_osc_ctrl #(
  parameter int NOTE_W = 7,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_num,
  output logic              note_ready,
  input  logic              note_off,
  output logic              rom_en,
  output logic [NOTE_W-1:0] rom_addr,
  input  logic [PER_W-1:0]  rom_data,
  output logic              step,
  output logic              squ,
  output logic              active,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cnt_nxt;
  logic             hit_nxt;

  // Handshake/strobe outputs decode directly from the state register.
`ifdef NOTE_OSC_RETRIG_EN
  assign note_ready = (state == S_IDLE) || (state == S_RUN);
`else
  assign note_ready = (state == S_IDLE);
`endif
  assign rom_en = (state == S_FETCH);
  assign active = (state == S_RUN);

  // Next counter value. step/squ are registered from the *next* count so the
  // pulse is visible in exactly the cycle where the counter sits at zero;
  // that puts the first step at T+2+P and makes P=1 step every RUN cycle.
  // The reload path only runs when the count is already zero, so cnt never
  // wraps below zero (the LOAD path is not stored when rom_data is 0).
  always_comb begin
    cnt_nxt = cnt - PER_ONE;
    if (state == S_LOAD) begin
      cnt_nxt = rom_data - PER_ONE;
    end else if (cnt == '0) begin
      cnt_nxt = period - PER_ONE;
    end
  end

  assign hit_nxt = (cnt_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      period   <= '0;
      cnt      <= '0;
      step     <= 1'b0;
      squ      <= 1'b0;
      err      <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        S_IDLE: begin
          if (note_valid) begin
            rom_addr <= note_num;
            err      <= 1'b0;
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          state <= note_off ? S_IDLE : S_LOAD;
        end

        S_LOAD: begin
          if (note_off) begin
            // Abort: the ROM word is dropped and err keeps its value.
            state <= S_IDLE;
          end else begin
            period <= rom_data;
            if (rom_data == '0) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              cnt   <= cnt_nxt;
              step  <= hit_nxt;
              squ   <= hit_nxt;
              state <= S_RUN;
            end
          end
        end

        default: begin // S_RUN
`ifdef NOTE_OSC_RETRIG_EN
          if (note_valid) begin
            // A new request beats a simultaneous note_off.
            rom_addr <= note_num;
            err      <= 1'b0;
            state    <= S_FETCH;
          end else
`endif
          if (note_off) begin
            squ   <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt  <= cnt_nxt;
            step <= hit_nxt;
            squ  <= squ ^ hit_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_osc_ctrl.sv
// tb_note_osc_ctrl: cycle-by-cycle checker for note_osc_ctrl (default build).
// The reference predicts every output from the acceptance cycle of the
// current note and its ROM word using plain timeline arithmetic.

module tb_note_osc_ctrl;
  localparam int NOTE_W = 7;
  localparam int PER_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              note_valid = 1'b0;
  logic [NOTE_W-1:0] note_num = '0;
  logic              note_off = 1'b0;
  logic              note_ready;
  logic              rom_en;
  logic [NOTE_W-1:0] rom_addr;
  logic [PER_W-1:0]  rom_data = '0;
  logic              step;
  logic              squ;
  logic              active;
  logic              err;

  logic [PER_W-1:0] rom [128];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference state: is a note in flight, when was it accepted, its word.
  bit                m_busy = 1'b0;
  int                m_tacc = 0;
  int                m_p    = 0;
  bit                m_err  = 1'b0;
  logic [NOTE_W-1:0] m_addr = '0;

  note_osc_ctrl #(.NOTE_W(NOTE_W), .PER_W(PER_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .note_valid (note_valid),
    .note_num   (note_num),
    .note_ready (note_ready),
    .note_off   (note_off),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .step       (step),
    .squ        (squ),
    .active     (active),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Registered ROM model.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: check the current cycle against the timeline, then drive the
  // inputs for this cycle and advance the reference.
  task automatic tick(input bit r, input bit v, input logic [NOTE_W-1:0] n, input bit off);
    int d;
    bit e_act, e_step, e_squ;
    @(negedge clk);
    d      = cyc - m_tacc;
    e_act  = m_busy && (d >= 3);
    e_step = 1'b0;
    e_squ  = 1'b0;
    if (e_act) begin
      // Steps land at T+2+k*P for k >= 1; squ reflects the step count parity.
      e_step = ((d - 2) % m_p) == 0;
      e_squ  = (((d - 2) / m_p) % 2) == 1;
    end
    check("note_ready", note_ready, !m_busy);
    check("rom_en",     rom_en,     m_busy && (d == 1));
    check("rom_addr",   rom_addr,   m_addr);
    check("active",     active,     e_act);
    check("step",       step,       e_step);
    check("squ",        squ,        e_squ);
    check("err",        err,        m_err);

    rst        = r;
    note_valid = v;
    note_num   = n;
    note_off   = off;

    if (r) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_addr = '0;
    end else if (!m_busy) begin
      if (v) begin
        m_busy = 1'b1;
        m_tacc = cyc;
        m_p    = int'(rom[n]);
        m_addr = n;
        m_err  = 1'b0;
      end
    end else begin
      if (off) begin
        m_busy = 1'b0;
      end else if (d == 2 && m_p == 0) begin
        m_busy = 1'b0;
        m_err  = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic req(input logic [NOTE_W-1:0] n);
    tick(1'b0, 1'b1, n, 1'b0);
  endtask

  task automatic stop();
    tick(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = PER_W'($urandom_range(1, 40));
    rom[69]  = 16'd916;
    rom[5]   = 16'd0;
    rom[119] = 16'd51;
    rom[10]  = 16'd1;
    rom[57]  = 16'd300;
    rom[20]  = 16'd0;
    rom[30]  = 16'd0;
    rom[11]  = 16'd2;

    rst = 1'b1;
    @(posedge clk);
    tick(1'b1, 1'b0, '0, 1'b0);   // reset values
    idle(3);

    // Long note: steps at T+918 and T+1834, squ 0->1->0.
    req(7'd69);
    idle(1900);
    stop();
    idle(5);

    // Zero word sets err, then a valid note clears it.
    req(7'd5);
    idle(6);
    req(7'd119);
    idle(130);
    stop();
    idle(3);

    // Period 1 and 2.
    req(7'd10);
    idle(8);
    stop();
    idle(2);
    req(7'd11);
    idle(9);
    stop();
    idle(2);

    // note_off during FETCH and during LOAD, with err set beforehand.
    req(7'd5);
    idle(5);
    req(7'd57);
    stop();
    idle(5);
    req(7'd5);
    idle(5);
    req(7'd57);
    idle(1);
    stop();
    idle(5);

    // Requests ignored while running, then reset mid-count.
    req(7'd119);
    idle(40);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 7'($urandom_range(0, 127)), 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 5) == 0),
           7'($urandom_range(0, 127)),
           ($urandom_range(0, 49) == 0));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
